// File: rtl/tiny_rv_pkg.sv
// rtl/tiny_rv_pkg.sv - shared register-file types and constants
package tiny_rv_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t         rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/tiny_rv_rf_writeback_if.sv
// rtl/tiny_rv_rf_writeback_if.sv - issue, ALU, load and register-file write signals
interface tiny_rv_rf_writeback_if;
  import tiny_rv_pkg::*;

  logic             i_issue_valid;
  reg_addr_t        i_issue_rd;
  logic [31:0]      o_pending;
  logic             i_alu_valid;
  logic             o_alu_ready;
  reg_addr_t        i_alu_rd;
  logic [XLEN-1:0]  i_alu_data;
  logic             i_ld_valid;
  logic             o_ld_ready;
  reg_addr_t        i_ld_rd;
  logic [XLEN-1:0]  i_ld_data;
  reg_addr_t        o_rf_waddr;
  logic [XLEN-1:0]  o_rf_wdata;

  modport master (
    output i_issue_valid, i_issue_rd,
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_pending, o_alu_ready, o_ld_ready, o_rf_waddr, o_rf_wdata
  );

  modport slave (
    input  i_issue_valid, i_issue_rd,
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_pending, o_alu_ready, o_ld_ready, o_rf_waddr, o_rf_wdata
  );

endinterface

// File: rtl/tiny_rv_wb_fifo.sv
// rtl/tiny_rv_wb_fifo.sv - power-of-two FIFO of pending load write-backs
module tiny_rv_wb_fifo
  import tiny_rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_push,
  input  wb_req_t i_push_data,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tiny_rv_rf_writeback.sv
// rtl/tiny_rv_rf_writeback.sv - merges ALU and load results onto the register-file write port
module tiny_rv_rf_writeback
  import tiny_rv_pkg::*;
#(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  tiny_rv_rf_writeback_if.slave wb
);

  wb_req_t     lq_head;
  wb_req_t     lq_in;
  logic        lq_full;
  logic        lq_empty;
  logic        lq_push;
  logic        lq_pop;

  logic [3:0]  starve_cnt;
  logic        starved;
  logic        alu_xfer;
  logic        alu_wr;
  logic        ld_wr;

  wb_req_t     w_q;
  wb_req_t     w_d;
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign lq_in.rd   = wb.i_ld_rd;
  assign lq_in.data = wb.i_ld_data;

  // x0 loads complete the handshake but never enter the buffer.
  assign lq_push = wb.i_ld_valid && !lq_full && (wb.i_ld_rd != REG_X0);

  tiny_rv_wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (lq_push),
    .i_push_data (lq_in),
    .i_pop       (lq_pop),
    .o_head      (lq_head),
    .o_full      (lq_full),
    .o_empty     (lq_empty)
  );

  assign starved  = !lq_empty && (starve_cnt == 4'(STARVE_MAX));
  assign alu_xfer = wb.i_alu_valid && !starved;
  assign alu_wr   = alu_xfer && (wb.i_alu_rd != REG_X0);
  // Load head takes any cycle the ALU does not claim W, including x0 ALU cycles.
  assign ld_wr    = !lq_empty && !alu_wr;
  assign lq_pop   = ld_wr;

  always_comb begin
    w_d = '0;
    if (alu_wr) begin
      w_d.rd   = wb.i_alu_rd;
      w_d.data = wb.i_alu_data;
    end else if (ld_wr) begin
      w_d = lq_head;
    end
  end

  // W held this cycle is being captured by the file, so its bit clears now.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wb.i_issue_valid && (wb.i_issue_rd != REG_X0)) set_mask[wb.i_issue_rd] = 1'b1;
    clr_mask[w_q.rd] = 1'b1;
    pending_d        = (pending_q & ~clr_mask) | set_mask;
    pending_d[0]     = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_q        <= '0;
      pending_q  <= '0;
      starve_cnt <= '0;
    end else begin
      w_q       <= w_d;
      pending_q <= pending_d;
      if (lq_empty || ld_wr) begin
        starve_cnt <= '0;
      end else if (alu_xfer) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign wb.o_alu_ready = !starved;
  assign wb.o_ld_ready  = !lq_full;
  assign wb.o_rf_waddr  = w_q.rd;
  assign wb.o_rf_wdata  = w_q.data;
  assign wb.o_pending   = pending_q;

endmodule

// File: doc/tiny_rv_rf_writeback.md
# tiny_rv_rf_writeback

Write-side driver for the core's 2-read/1-write register file. It merges ALU results with buffered load results onto the file's single write port, which has no write enable. It also keeps a 32-bit pending-write scoreboard that the issue stage uses for RAW hazard checks. It sits between the execute/load units and the register file; its write outputs connect directly to the file's write address and write data inputs.

## Interface
- `LQ_DEPTH`, 2: load-result buffer entries; power of two, ≥2.
- `STARVE_MAX`, 4: consecutive cycles a waiting load may lose arbitration before it is forced through; range 1–15.

Ports:
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_issue_valid`  in  1  an instruction that writes `i_issue_rd` is issued this cycle.
- `i_issue_rd`  in  5  destination register to mark pending.
- `o_pending`  out  32  bit n = 1 while a write to xn is outstanding; bit 0 is always 0.
- `i_alu_valid`  in  1  ALU result present.
- `o_alu_ready`  out  1  ALU result accepted this cycle.
- `i_alu_rd`  in  5  ALU destination register.
- `i_alu_data`  in  32  ALU result.
- `i_ld_valid`  in  1  load result present.
- `o_ld_ready`  out  1  load buffer can accept a result.
- `i_ld_rd`  in  5  load destination register.
- `i_ld_data`  in  32  load data.
- `o_rf_waddr`  out  5  register file write address; registered.
- `o_rf_wdata`  out  32  register file write data; registered.

## Operation
- The register file writes every cycle, so an idle cycle drives `o_rf_waddr`=0 and `o_rf_wdata`=0. This is a harmless x0 write.
- Write-stage register W holds (`o_rf_waddr`, `o_rf_wdata`). Each cycle W is loaded with exactly one of: the ALU result, the load buffer head, or idle.
- Arbitration: the ALU wins by default. The load buffer head wins when the ALU is idle or when the starvation counter equals `STARVE_MAX`.
- `o_alu_ready` = !(buffer non-empty && counter == `STARVE_MAX`). It is combinational and does not depend on `i_alu_valid`.
- Starvation counter (4 bits):
  - increments each cycle the buffer is non-empty and an ALU transfer occurs;
  - clears when a load is written or when the buffer is empty.
- Load buffer: a FIFO of `LQ_DEPTH` entries holding {rd, data}.
  - Enqueue on `i_ld_valid` && `o_ld_ready`.
  - `o_ld_ready` = !full and is registered-state derived. A dequeue in the same cycle does not raise it.
  - Enqueue and dequeue in the same cycle are both legal when not full.
- rd = 0 results: accepted (ALU on ready, load on enqueue) and discarded. They never occupy W and never enter the buffer.
- Scoreboard:
  - Set bit rd on `i_issue_valid` when rd ≠ 0.
  - Clear bit `o_rf_waddr` on the edge at which the register file captures W, i.e. the cycle after W was loaded.
  - If set and clear hit the same bit in one cycle, set wins.
- Bus pass-through: no data reordering between sources. Two ALU results to the same rd retire in order, and a load queued behind them retires later.

## Timing
- Reset (async assert, sync release): W = 0/0, buffer empty, `o_ld_ready`=1, `o_pending`=0, counter=0, `o_alu_ready`=1.
- Reset mid-operation discards buffered loads and the scoreboard. Register file contents are not cleared.
- ALU path: result accepted at edge k → W loaded at k → file written and pending cleared at k+1. A read in cycle k+1 returns the new value.
- Load path: enqueued at edge k → earliest W load at k+1 → file written at k+2.
- Buffer full: `o_ld_ready`=0 until the cycle after a dequeue.
- Throughput: one write per cycle.

## Structure
- Shared `tiny_rv_pkg`:
  - `reg_addr_t` (logic [4:0]);
  - `wb_req_t` struct {rd, data};
  - `REG_X0` constant.
- One sub-module, `tiny_rv_wb_fifo`: parameterized-depth FIFO of `wb_req_t` with full/empty flags. Arbitration, the starvation counter and the scoreboard stay in the top module.

## Test plan
- **Reset idle:** reset released with no inputs → `o_rf_waddr`=0, `o_rf_wdata`=0, `o_pending`=0 for 10 cycles.
- **ALU write:** issue x5, then ALU {x5, 0xDEADBEEF} → W shows x5/0xDEADBEEF for one cycle; `o_pending[5]` falls one cycle later; the file reads 0xDEADBEEF.
- **Starvation:** load {x7, 0x1234} enqueued while the ALU is valid every cycle → ALU wins 4 cycles; `o_alu_ready`=0 on the 5th cycle; W = x7/0x1234; the counter resets.
- **Buffer full:** 3 loads back-to-back under continuous ALU traffic with `LQ_DEPTH`=2 → the third is held by `o_ld_ready`=0 until one cycle after the first dequeue; all three retire in order.
- **Scoreboard collision:** issue x9 in the same cycle that a previous x9 write clears → `o_pending[9]` stays 1.
- **x0 and async reset:** an ALU result to x0 is consumed with W idle and `o_pending[0]` stays 0. Asserting `i_rst_n` low mid-transfer with 2 loads queued → buffer empty and `o_pending`=0 immediately.
